mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 8, operand width in bits (2..32).
REQ-003 Parameter RESULT_W, default 8, result width in bits (1..2*DATA_W).
REQ-004 Parameter LATENCY, default 2, pipeline stages from accept to result (1..8).
REQ-005 Port clk  input  1  rising-edge clock for all state.
REQ-006 Port reset  input  1  asynchronous active-high reset.
REQ-007 Port in_valid  input  1  operands and mode bits valid this cycle.
REQ-008 Port in_ready  output  1  block accepts an operation this cycle.
REQ-009 Port a  input  DATA_W  first operand.
REQ-010 Port b  input  DATA_W  second operand.
REQ-011 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-012 Port sat_en  input  1  1 = saturate to RESULT_W, 0 = truncate; sampled with operands.
REQ-013 Port out_valid  output  1  result/overflow valid.
REQ-014 Port out_ready  input  1  downstream accepts the result.
REQ-015 Port result  output  RESULT_W  product after truncation or saturation.
REQ-016 Port overflow  output  1  full product not representable in RESULT_W.
REQ-017 Port busy  output  1  at least one pipeline stage holds a valid operation.

Function
REQ-018 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out on a rising edge with out_valid=1 and out_ready=1.
REQ-019 Pipeline SHALL be LATENCY stages, each carrying a valid bit plus data and mode bits; all stages advance together when advance = !out_valid | out_ready.
REQ-020 in_ready SHALL equal advance (combinational); when advance=0 every stage, result, overflow and out_valid SHALL hold unchanged.
REQ-021 With no stall, an operation accepted at edge k SHALL present out_valid=1 after edge k+LATENCY-1 (i.e. observable in cycle following edge k+LATENCY-1); throughput one operation per cycle.
REQ-022 Bubbles (in_valid=0 on an advancing edge) SHALL propagate as invalid stages; no reordering, no duplication, no loss.
REQ-023 Full product SHALL be 2*DATA_W bits, signed or unsigned per the operation's sampled signed_mode.
REQ-024 overflow SHALL be 1 when the full product lies outside [0, 2^RESULT_W-1] (unsigned) or [-2^(RESULT_W-1), 2^(RESULT_W-1)-1] (signed), independent of sat_en.
REQ-025 sat_en=0: result SHALL be the low RESULT_W bits of the full product.
REQ-026 sat_en=1: on overflow result SHALL clamp to the range bound nearest the true product; otherwise equal the low RESULT_W bits.
REQ-027 When out_valid=0 result and overflow SHALL hold their last values (don't-care to consumers).
REQ-028 busy SHALL be the OR of all stage valid bits including the output stage.
REQ-029 Mode bits SHALL travel with their operands; changing signed_mode/sat_en mid-stream SHALL affect only newly accepted operations.

Reset
REQ-030 While reset=1, all valid bits, out_valid, result, overflow and busy SHALL be 0 immediately, independent of clk.
REQ-031 Reset mid-operation SHALL discard every in-flight operation; none SHALL emerge after reset release.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Verification (DATA_W=8, RESULT_W=8, LATENCY=2 unless stated)
REQ-033 Unsigned 15*17, out_ready=1 -> out_valid exactly LATENCY edges after accept, result=0xFF, overflow=0.
REQ-034 Unsigned 16*16: sat_en=0 -> result=0x00, overflow=1; sat_en=1 -> result=0xFF, overflow=1.
REQ-035 Signed (-128)*(-1): sat_en=1 -> 0x7F, overflow=1; sat_en=0 -> 0x80, overflow=1; signed (-8)*16 -> 0x80, overflow=0; signed (-16)*16 sat -> 0x80, overflow=1.
REQ-036 Back-to-back 1*1, 2*2, 3*3, out_ready=0 when first result appears for 3 cycles -> in_ready=0, result=0x01 held stable, then 0x01, 0x04, 0x09 in order, no loss.
REQ-037 Accept 5*5 and 6*6 on consecutive edges, pulse reset between clock edges -> outputs 0 at once, out_valid never asserts for either, busy=0.
REQ-038 Repeat REQ-033 and REQ-036 with LATENCY=1 and LATENCY=4, DATA_W=16, RESULT_W=32 -> latency equals LATENCY, results exact full products, overflow=0.

Source files
------------

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier with truncate or saturate per operation; result LATENCY cycles after accept.
// All stages advance together when the output is empty or consumed; a stalled output freezes the pipe and drops in_ready.
module mult_pipe #(
    parameter int DATA_W   = 8,
    parameter int RESULT_W = 8,
    parameter int LATENCY  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                signed_mode,
    input  logic                sat_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] result,
    output logic                overflow,
    output logic                busy
);
    localparam int PW = 2 * DATA_W;

    logic                advance;
    logic [LATENCY-1:0]  stg_vld;
    logic [LATENCY-1:0]  stg_sm;
    logic [LATENCY-1:0]  stg_sat;
    logic [DATA_W-1:0]   stg_a [LATENCY];
    logic [DATA_W-1:0]   stg_b [LATENCY];

    logic [DATA_W-1:0]   out_a;
    logic [DATA_W-1:0]   out_b;
    logic                out_sm;
    logic                out_sat;
    logic [PW-1:0]       ext_a;
    logic [PW-1:0]       ext_b;
    logic [PW-1:0]       prod;
    logic                ovf_u;
    logic                ovf_s;
    logic                ovf;
    logic [RESULT_W-1:0] sat_min;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = stg_vld[LATENCY-1];
    assign busy      = |stg_vld;

    // Operand/mode registers only load under a valid op, so the output stage keeps its last result across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_vld <= '0;
            stg_sm  <= '0;
            stg_sat <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_a[i] <= '0;
                stg_b[i] <= '0;
            end
        end else if (advance) begin
            stg_vld[0] <= in_valid;
            if (in_valid) begin
                stg_a[0]   <= a;
                stg_b[0]   <= b;
                stg_sm[0]  <= signed_mode;
                stg_sat[0] <= sat_en;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                if (stg_vld[i-1]) begin
                    stg_a[i]   <= stg_a[i-1];
                    stg_b[i]   <= stg_b[i-1];
                    stg_sm[i]  <= stg_sm[i-1];
                    stg_sat[i] <= stg_sat[i-1];
                end
            end
        end
    end

    assign out_a   = stg_a[LATENCY-1];
    assign out_b   = stg_b[LATENCY-1];
    assign out_sm  = stg_sm[LATENCY-1];
    assign out_sat = stg_sat[LATENCY-1];

    // Extending to the full product width makes one unsigned multiply correct for both modes.
    assign ext_a = out_sm ? {{DATA_W{out_a[DATA_W-1]}}, out_a} : {{DATA_W{1'b0}}, out_a};
    assign ext_b = out_sm ? {{DATA_W{out_b[DATA_W-1]}}, out_b} : {{DATA_W{1'b0}}, out_b};
    assign prod  = ext_a * ext_b;

    generate
        if (RESULT_W < PW) begin : g_narrow
            assign ovf_u = |prod[PW-1:RESULT_W];
            assign ovf_s = !(&prod[PW-1:RESULT_W-1]) && (|prod[PW-1:RESULT_W-1]);
        end else begin : g_full
            assign ovf_u = 1'b0;
            assign ovf_s = 1'b0;
        end
    endgenerate

    always_comb begin
        sat_min              = '0;
        sat_min[RESULT_W-1]  = 1'b1;
        ovf                  = out_sm ? ovf_s : ovf_u;
        result               = prod[RESULT_W-1:0];
        if (out_sat && ovf) begin
            if (!out_sm) begin
                result = '1;
            end else if (prod[PW-1]) begin
                result = sat_min;
            end else begin
                result = ~sat_min;
            end
        end
        overflow = ovf;
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboarded bench for mult_pipe: one 8x8->8 LATENCY=2 instance and two 16x16->32 instances (LATENCY=1 and 4).
module tb_mult_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sm  = 1'b0;
    logic sat = 1'b0;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, ordy0 = 1'b1, ir0, ov0, of0, busy0;
    logic [7:0]  a0 = '0, b0 = '0, res0;
    logic        v1 = 1'b0, ordy1 = 1'b1, ir1, ov1, of1, busy1;
    logic        v2 = 1'b0, ordy2 = 1'b1, ir2, ov2, of2, busy2;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] res1, res2;

    int errors = 0;
    int checks = 0;
    logic [64:0] q0[$], q1[$], q2[$];
    logic [63:0] got0[$], got1[$], got2[$];

    mult_pipe #(.DATA_W(8), .RESULT_W(8), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst), .in_valid(v0), .in_ready(ir0), .a(a0), .b(b0),
        .signed_mode(sm), .sat_en(sat), .out_valid(ov0), .out_ready(ordy0),
        .result(res0), .overflow(of0), .busy(busy0));
    mult_pipe #(.DATA_W(16), .RESULT_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(v1), .in_ready(ir1), .a(a16), .b(b16),
        .signed_mode(sm), .sat_en(sat), .out_valid(ov1), .out_ready(ordy1),
        .result(res1), .overflow(of1), .busy(busy1));
    mult_pipe #(.DATA_W(16), .RESULT_W(32), .LATENCY(4)) dut2 (
        .clk(clk), .reset(rst), .in_valid(v2), .in_ready(ir2), .a(a16), .b(b16),
        .signed_mode(sm), .sat_en(sat), .out_valid(ov2), .out_ready(ordy2),
        .result(res2), .overflow(of2), .busy(busy2));

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, then range test and clamp.
    function automatic logic [64:0] model(logic [31:0] av, logic [31:0] bv, logic smv, logic satv, int dw, int rw);
        longint m, fa, fb, p, lo, hi, v;
        logic ovf;
        m  = (longint'(1) << dw) - 1;
        fa = longint'(av) & m;
        fb = longint'(bv) & m;
        if (smv && av[dw-1]) fa = fa - (longint'(1) << dw);
        if (smv && bv[dw-1]) fb = fb - (longint'(1) << dw);
        p = fa * fb;
        if (smv) begin
            lo = -(longint'(1) << (rw - 1));
            hi = (longint'(1) << (rw - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << rw) - 1;
        end
        ovf = (p < lo) || (p > hi);
        v = p;
        if (ovf && satv) v = (p < lo) ? lo : hi;
        return {ovf, 64'(v & ((longint'(1) << rw) - 1))};
    endfunction

    task automatic sb_cmp(string tag, int sz, logic [64:0] e, logic [63:0] r, logic o);
        chk({tag, "_expected"}, 64'(sz > 0), 64'(1));
        if (sz > 0) begin
            chk({tag, "_res"}, r, e[63:0]);
            chk({tag, "_ovf"}, 64'(o), 64'(e[64]));
        end
    endtask

    always @(posedge rst) begin
        q0.delete(); q1.delete(); q2.delete();
    end

    always @(negedge clk) begin : mon
        int sz;
        logic [64:0] e;
        if (!rst) begin
            if (v0 && ir0) q0.push_back(model({24'b0, a0}, {24'b0, b0}, sm, sat, 8, 8));
            if (v1 && ir1) q1.push_back(model({16'b0, a16}, {16'b0, b16}, sm, sat, 16, 32));
            if (v2 && ir2) q2.push_back(model({16'b0, a16}, {16'b0, b16}, sm, sat, 16, 32));
            if (ov0 && ordy0) begin
                sz = q0.size(); e = '0;
                if (sz > 0) e = q0.pop_front();
                sb_cmp("sb0", sz, e, 64'(res0), of0);
                got0.push_back(64'(res0));
            end
            if (ov1 && ordy1) begin
                sz = q1.size(); e = '0;
                if (sz > 0) e = q1.pop_front();
                sb_cmp("sb1", sz, e, 64'(res1), of1);
                got1.push_back(64'(res1));
            end
            if (ov2 && ordy2) begin
                sz = q2.size(); e = '0;
                if (sz > 0) e = q2.pop_front();
                sb_cmp("sb2", sz, e, 64'(res2), of2);
                got2.push_back(64'(res2));
            end
        end
    end

    function automatic logic ov_of(int w);
        case (w) 0: return ov0; 1: return ov1; default: return ov2; endcase
    endfunction
    function automatic logic ir_of(int w);
        case (w) 0: return ir0; 1: return ir1; default: return ir2; endcase
    endfunction
    function automatic logic v_of(int w);
        case (w) 0: return v0; 1: return v1; default: return v2; endcase
    endfunction
    function automatic logic of_of(int w);
        case (w) 0: return of0; 1: return of1; default: return of2; endcase
    endfunction
    function automatic logic busy_of(int w);
        case (w) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic [63:0] res_of(int w);
        case (w) 0: return 64'(res0); 1: return 64'(res1); default: return 64'(res2); endcase
    endfunction
    function automatic int got_size(int w);
        case (w) 0: return got0.size(); 1: return got1.size(); default: return got2.size(); endcase
    endfunction
    function automatic logic [63:0] got_at(int w, int i);
        if (i >= got_size(w)) return '1;
        case (w) 0: return got0[i]; 1: return got1[i]; default: return got2[i]; endcase
    endfunction

    task automatic got_clear(int w);
        case (w) 0: got0.delete(); 1: got1.delete(); default: got2.delete(); endcase
    endtask
    task automatic drive(int w, logic v, logic [15:0] av, logic [15:0] bv);
        case (w)
            0: begin v0 = v; a0 = av[7:0]; b0 = bv[7:0]; end
            1: begin v1 = v; a16 = av; b16 = bv; end
            default: begin v2 = v; a16 = av; b16 = bv; end
        endcase
    endtask
    task automatic set_ordy(int w, logic r);
        case (w) 0: ordy0 = r; 1: ordy1 = r; default: ordy2 = r; endcase
    endtask

    // Single operation on an idle pipe; called and returns at posedge+1.
    task automatic op_test(string tag, int w, logic [15:0] av, logic [15:0] bv, logic smv, logic satv,
                           logic [63:0] er, logic eo, int el);
        int cnt;
        set_ordy(w, 1'b1);
        sm = smv; sat = satv;
        drive(w, 1'b1, av, bv);
        @(posedge clk); #1;
        drive(w, 1'b0, 16'h0, 16'h0);
        chk({tag, "_busy"}, 64'(busy_of(w)), 64'(1));
        cnt = 1;
        while (!ov_of(w) && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_valid"}, 64'(ov_of(w)), 64'(1));
        if (el > 0) chk({tag, "_latency"}, 64'(cnt), 64'(el));
        chk({tag, "_res"}, res_of(w), er);
        chk({tag, "_ovf"}, 64'(of_of(w)), 64'(eo));
        @(posedge clk); #1;
    endtask

    // 1*1, 2*2, 3*3 back to back; output stalled 3 cycles when the first result appears.
    task automatic stall_test(int w);
        int  n_sent = 0;
        int  stall = 0;
        logic seen = 1'b0;
        logic acc;
        got_clear(w);
        set_ordy(w, 1'b1);
        sm = 1'b0; sat = 1'b0;
        for (int cyc = 0; cyc < 40 && !(n_sent == 3 && got_size(w) == 3); cyc++) begin
            drive(w, n_sent < 3, 16'(n_sent + 1), 16'(n_sent + 1));
            @(negedge clk);
            acc = v_of(w) && ir_of(w);
            if (stall > 0) begin
                chk("stall_in_ready", 64'(ir_of(w)), 64'(0));
                chk("stall_valid", 64'(ov_of(w)), 64'(1));
                chk("stall_res_hold", res_of(w), 64'(1));
            end
            @(posedge clk); #1;
            if (acc) n_sent++;
            if (stall > 0) begin
                stall--;
                if (stall == 0) set_ordy(w, 1'b1);
            end else if (ov_of(w) && !seen) begin
                seen = 1'b1;
                set_ordy(w, 1'b0);
                stall = 3;
            end
        end
        drive(w, 1'b0, 16'h0, 16'h0);
        chk("stall_count", 64'(got_size(w)), 64'(3));
        for (int k = 0; k < 3; k++) chk("stall_order", got_at(w, k), 64'((k + 1) * (k + 1)));
    endtask

    // Two ops in flight, asynchronous reset pulse between edges.
    task automatic reset_test(int w);
        logic any_ov = 1'b0;
        set_ordy(w, 1'b1);
        sm = 1'b0; sat = 1'b0;
        drive(w, 1'b1, 16'd5, 16'd5);
        @(posedge clk); #1;
        drive(w, 1'b1, 16'd6, 16'd6);
        @(posedge clk); #1;
        drive(w, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        chk("rst_res", res_of(w), 64'(0));
        chk("rst_ovf", 64'(of_of(w)), 64'(0));
        chk("rst_valid", 64'(ov_of(w)), 64'(0));
        chk("rst_busy", 64'(busy_of(w)), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(ir_of(w)), 64'(1));
        repeat (8) begin
            @(negedge clk);
            any_ov = any_ov | ov_of(w);
        end
        chk("rst_no_emerge", 64'(any_ov), 64'(0));
        chk("rst_busy_after", 64'(busy_of(w)), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset_res", 64'(res0), 64'(0));
        chk("reset_ovf", 64'(of0), 64'(0));
        chk("reset_valid", 64'(ov0), 64'(0));
        chk("reset_busy", 64'({busy0, busy1, busy2}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("first_in_ready", 64'({ir0, ir1, ir2}), 64'(3'b111));
        @(posedge clk); #1;

        op_test("u15x17",     0, 16'd15,   16'd17,   1'b0, 1'b0, 64'hFF, 1'b0, 2);
        op_test("u16x16_trn", 0, 16'd16,   16'd16,   1'b0, 1'b0, 64'h00, 1'b1, 2);
        op_test("u16x16_sat", 0, 16'd16,   16'd16,   1'b0, 1'b1, 64'hFF, 1'b1, 2);
        op_test("s128x1_sat", 0, 16'h80,   16'hFF,   1'b1, 1'b1, 64'h7F, 1'b1, 2);
        op_test("s128x1_trn", 0, 16'h80,   16'hFF,   1'b1, 1'b0, 64'h80, 1'b1, 2);
        op_test("s8x16",      0, 16'hF8,   16'h10,   1'b1, 1'b1, 64'h80, 1'b0, 2);
        op_test("s16x16_sat", 0, 16'hF0,   16'h10,   1'b1, 1'b1, 64'h80, 1'b1, 2);

        // Mode bits change every accept, with a bubble in the middle.
        got_clear(0);
        sm = 1'b0; sat = 1'b0; drive(0, 1'b1, 16'hFF, 16'hFF);
        @(posedge clk); #1;
        sm = 1'b1; drive(0, 1'b1, 16'hFF, 16'hFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        sm = 1'b0; sat = 1'b1; drive(0, 1'b1, 16'h20, 16'h20);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0); sat = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("mode_count", 64'(got_size(0)), 64'(3));
        chk("mode_u_ff",  got_at(0, 0), 64'h01);
        chk("mode_s_ff",  got_at(0, 1), 64'h01);
        chk("mode_u_sat", got_at(0, 2), 64'hFF);

        stall_test(0);

        op_test("l1_15x17",  1, 16'd15,   16'd17,   1'b0, 1'b0, 64'd255,        1'b0, 1);
        op_test("l1_ffff",   1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 64'hFFFE0001,   1'b0, 1);
        op_test("l1_s8000",  1, 16'h8000, 16'h8000, 1'b1, 1'b1, 64'h40000000,   1'b0, 1);
        op_test("l1_sneg",   1, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 64'hFFFFFFFE,   1'b0, 1);
        stall_test(1);

        op_test("l4_15x17",  2, 16'd15,   16'd17,   1'b0, 1'b0, 64'd255,        1'b0, 4);
        op_test("l4_ffff",   2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 64'hFFFE0001,   1'b0, 4);
        op_test("l4_sneg",   2, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 64'hC0008000,   1'b0, 4);
        stall_test(2);

        chk("drain_q0", 64'(q0.size()), 64'(0));
        chk("drain_q1", 64'(q1.size()), 64'(0));
        chk("drain_q2", 64'(q2.size()), 64'(0));

        reset_test(0);
        reset_test(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
